// File: rtl/magia_tile_pkg.sv
// Shared types and constants for the MAGIA tile boot/wake-up controller.
// Holds the FSM state encoding, config-port register offsets and CTRL bit positions.
// No logic lives here; it is imported by the interface, the counter and the top.
package magia_tile_pkg;

    typedef enum logic [1:0] {
        BOOT_IDLE   = 2'd0,
        BOOT_ENABLE = 2'd1,
        BOOT_RUN    = 2'd2,
        BOOT_DRAIN  = 2'd3
    } boot_ctrl_state_e;

    // Byte offsets on the 4-bit config address.
    localparam logic [3:0] BOOT_CTRL_OFS   = 4'h0;
    localparam logic [3:0] BOOT_ADDR_OFS   = 4'h4;
    localparam logic [3:0] BOOT_STATUS_OFS = 4'h8;
    localparam logic [3:0] BOOT_EVT_OFS    = 4'hC;

    // CTRL register bit positions.
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_HALT_BIT  = 1;

endpackage

// File: rtl/magia_tile_boot_ctrl_if.sv
// Config port bundle of the tile boot controller (req/gnt request, rvalid response).
// Latency: gnt is combinational, rvalid/rdata/err follow one cycle after the grant.
// Backpressure: none, every request is granted in the cycle it is presented.
//   req/we/addr/wdata : master -> slave request
//   gnt               : slave -> master, equal to req
//   rvalid/rdata/err  : slave -> master registered response
interface magia_tile_boot_ctrl_if;
    import magia_tile_pkg::*;

    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/magia_sat_counter.sv
// Saturating up/down counter: adds inc_i (0..2) and subtracts dec_i in one step.
// Latency: new value visible one cycle after the inputs; clr_i overrides everything.
// Backpressure: none; the result is clamped to [0, 2^W-1] instead of wrapping.
//   clk_i, rst_ni : clock, async active-low reset (count returns to 0)
//   clr_i         : synchronous clear
//   inc_i, dec_i  : increment amount and decrement request
//   cnt_o         : current count
module magia_sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic [1:0]   inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);
    import magia_tile_pkg::*;

    localparam logic [W+1:0] MAX_CNT = {2'b00, {W{1'b1}}};

    logic [W-1:0] cnt_q, cnt_d;
    logic [W+1:0] sum_inc;
    logic [W+1:0] sum_net;

    // Two guard bits let the intermediate sum exceed 2^W-1 before clamping,
    // so a full counter plus inc=2 minus dec still lands on the maximum.
    always_comb begin
        sum_inc = {2'b00, cnt_q} + {{W{1'b0}}, inc_i};
        sum_net = sum_inc;
        if (dec_i && (sum_inc != '0)) begin
            sum_net = sum_inc - 1'b1;
        end
        cnt_d = (sum_net > MAX_CNT) ? {W{1'b1}} : sum_net[W-1:0];
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/magia_tile_boot_ctrl.sv
// Tile boot/wake sequencer: boot address register, enable->fetch start/halt FSM, wake-event release.
// Latency: tile_enable one cycle after START, fetch_enable ENABLE_DLY cycles later; cfg response 1 cycle.
// Backpressure: config port always granted; wake events beyond 2^CNT_W-1 pending are dropped.
//   clk_i, rst_ni          : clock, async active-low reset
//   cfg                    : config port (slave side of magia_tile_boot_ctrl_if)
//   wake_evt_i             : one pending wake per cycle high
//   core_sleep_i           : core WFE sleep status
//   tile_enable_o, fetch_enable_o, boot_addr_o, wu_wfe_o : core control pins
//   busy_o                 : FSM not in IDLE
module magia_tile_boot_ctrl #(
    parameter int unsigned ENABLE_DLY    = 8,
    parameter int unsigned CNT_W         = 4,
    parameter logic [31:0] BOOT_ADDR_RST = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    magia_tile_boot_ctrl_if.slave        cfg,
    input  logic                         wake_evt_i,
    input  logic                         core_sleep_i,
    output logic                         tile_enable_o,
    output logic                         fetch_enable_o,
    output logic [31:0]                  boot_addr_o,
    output logic                         wu_wfe_o,
    output logic                         busy_o
);
    import magia_tile_pkg::*;

    localparam logic [1:0] ST_IDLE   = BOOT_IDLE;
    localparam logic [1:0] ST_ENABLE = BOOT_ENABLE;
    localparam logic [1:0] ST_RUN    = BOOT_RUN;
    localparam logic [1:0] ST_DRAIN  = BOOT_DRAIN;

    localparam logic [7:0] DLY_LOAD = 8'(ENABLE_DLY - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       dly_q, dly_d;
    logic             tile_en_q, tile_en_d;
    logic             fetch_en_q, fetch_en_d;
    logic             from_enable_q, from_enable_d;
    logic             armed_q, armed_d;
    logic [31:0]      boot_addr_q, boot_addr_d;
    logic             rvalid_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             cfg_wr;
    logic             ctrl_wr, boot_wr, evt_wr;
    logic             start_req, halt_req;
    logic             cnt_clr;
    logic             wake_pulse;
    logic [CNT_W-1:0] evt_cnt;
    logic [31:0]      status_word;

    // ---------------- config decode ----------------
    assign cfg_wr    = cfg.req && cfg.we;
    assign ctrl_wr   = cfg_wr && (cfg.addr == BOOT_CTRL_OFS);
    assign boot_wr   = cfg_wr && (cfg.addr == BOOT_ADDR_OFS);
    assign evt_wr    = cfg_wr && (cfg.addr == BOOT_EVT_OFS);
    assign start_req = ctrl_wr && cfg.wdata[CTRL_START_BIT];
    assign halt_req  = ctrl_wr && cfg.wdata[CTRL_HALT_BIT];

    always_comb begin
        status_word                = '0;
        status_word[1:0]           = state_q;
        status_word[8 +: CNT_W]    = evt_cnt;
    end

    // ---------------- start/halt FSM ----------------
    always_comb begin
        state_d       = state_q;
        dly_d         = dly_q;
        tile_en_d     = tile_en_q;
        fetch_en_d    = fetch_en_q;
        from_enable_d = from_enable_q;
        boot_addr_d   = boot_addr_q;
        cnt_clr       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // HALT in the same write as START cancels it.
                if (start_req && !halt_req) begin
                    state_d       = ST_ENABLE;
                    tile_en_d     = 1'b1;
                    dly_d         = DLY_LOAD;
                    from_enable_d = 1'b0;
                end
            end
            ST_ENABLE: begin
                if (halt_req) begin
                    state_d       = ST_DRAIN;
                    fetch_en_d    = 1'b0;
                    from_enable_d = 1'b1;
                end else if (dly_q == 8'd0) begin
                    state_d    = ST_RUN;
                    fetch_en_d = 1'b1;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d       = ST_DRAIN;
                    fetch_en_d    = 1'b0;
                    from_enable_d = 1'b0;
                end
            end
            default: begin
                // A core that never fetched cannot reach WFE, so skip the sleep wait.
                if (from_enable_q || core_sleep_i) begin
                    state_d       = ST_IDLE;
                    tile_en_d     = 1'b0;
                    from_enable_d = 1'b0;
                    cnt_clr       = 1'b1;
                end
            end
        endcase

        // Boot address may only change while the core is held off.
        if (boot_wr && (state_q == ST_IDLE)) begin
            boot_addr_d = cfg.wdata;
        end
    end

    // ---------------- wake release ----------------
    // One pulse per sleep episode: armed drops with the pulse and is only
    // restored once the core is seen awake again.
    assign wake_pulse = (state_q == ST_RUN) && core_sleep_i &&
                        (evt_cnt != '0) && armed_q;

    always_comb begin
        armed_d = armed_q;
        if (wake_pulse) begin
            armed_d = 1'b0;
        end else if (!core_sleep_i) begin
            armed_d = 1'b1;
        end
    end

    magia_sat_counter #(
        .W (CNT_W)
    ) u_evt_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  ({1'b0, wake_evt_i} + {1'b0, evt_wr}),
        .dec_i  (wake_pulse),
        .cnt_o  (evt_cnt)
    );

    // ---------------- config response ----------------
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (cfg.req) begin
            if (cfg.we) begin
                case (cfg.addr)
                    BOOT_CTRL_OFS, BOOT_EVT_OFS: err_d = 1'b0;
                    BOOT_ADDR_OFS:               err_d = (state_q != ST_IDLE);
                    default:                     err_d = 1'b1;
                endcase
            end else begin
                case (cfg.addr)
                    BOOT_CTRL_OFS, BOOT_EVT_OFS: rdata_d = '0;
                    BOOT_ADDR_OFS:               rdata_d = boot_addr_q;
                    BOOT_STATUS_OFS:             rdata_d = status_word;
                    default:                     err_d   = 1'b1;
                endcase
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            dly_q         <= 8'd0;
            tile_en_q     <= 1'b0;
            fetch_en_q    <= 1'b0;
            from_enable_q <= 1'b0;
            armed_q       <= 1'b1;
            boot_addr_q   <= BOOT_ADDR_RST;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            dly_q         <= dly_d;
            tile_en_q     <= tile_en_d;
            fetch_en_q    <= fetch_en_d;
            from_enable_q <= from_enable_d;
            armed_q       <= armed_d;
            boot_addr_q   <= boot_addr_d;
            rvalid_q      <= cfg.req;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    assign cfg.gnt        = cfg.req;
    assign cfg.rvalid     = rvalid_q;
    assign cfg.rdata      = rdata_q;
    assign cfg.err        = err_q;

    assign tile_enable_o  = tile_en_q;
    assign fetch_enable_o = fetch_en_q;
    assign boot_addr_o    = boot_addr_q;
    assign wu_wfe_o       = wake_pulse;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_magia_tile_boot_ctrl.sv
// Directed bench for magia_tile_boot_ctrl: register-map vector table plus boot/halt/wake/reset sequences.
// Timing: inputs change on the falling edge, outputs are read on the falling edge (or 1 ns after it).
// All expected values are hand-computed constants for ENABLE_DLY=8, CNT_W=4.
module tb_magia_tile_boot_ctrl;

    logic        clk;
    logic        rst_n;
    logic        wake_evt;
    logic        core_sleep;
    logic        tile_en;
    logic        fetch_en;
    logic [31:0] boot_addr;
    logic        wu_wfe;
    logic        busy;

    int total;
    int bad;

    magia_tile_boot_ctrl_if bus ();

    magia_tile_boot_ctrl #(
        .ENABLE_DLY    (8),
        .CNT_W         (4),
        .BOOT_ADDR_RST (32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg            (bus),
        .wake_evt_i     (wake_evt),
        .core_sleep_i   (core_sleep),
        .tile_enable_o  (tile_en),
        .fetch_enable_o (fetch_en),
        .boot_addr_o    (boot_addr),
        .wu_wfe_o       (wu_wfe),
        .busy_o         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; request captured on the next rising edge,
    // response sampled on the falling edge after that.
    task automatic cfg_xfer(input logic we, input logic [3:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er,
                            output logic g, output logic rv);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = a;
        bus.wdata = wd;
        #1 g = bus.gnt;
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0;
        bus.we  = 1'b0;
        rv = bus.rvalid;
        rd = bus.rdata;
        er = bus.err;
    endtask

    task automatic rd_status(input string nm, input logic [31:0] exp);
        logic [31:0] rd;
        logic er, g, rv;
        cfg_xfer(1'b0, 4'h8, 32'h0, rd, er, g, rv);
        chk(nm, rd, exp);
    endtask

    task automatic wr_reg(input string nm, input logic [3:0] a, input logic [31:0] wd,
                          input logic exp_err);
        logic [31:0] rd;
        logic er, g, rv;
        cfg_xfer(1'b1, a, wd, rd, er, g, rv);
        chk(nm, {31'b0, er}, {31'b0, exp_err});
    endtask

    // START write, then count falling edges until fetch_enable rises.
    task automatic boot_seq(input string nm);
        int n;
        wr_reg({nm, "_start_err"}, 4'h0, 32'h1, 1'b0);
        chk({nm, "_tile_t1"}, {31'b0, tile_en}, 32'd1);
        chk({nm, "_fetch_t1"}, {31'b0, fetch_en}, 32'd0);
        n = 0;
        while (n < 20 && !fetch_en) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_fetch_delay"}, n, 32'd8);
    endtask

    initial begin
        logic [31:0] rd;
        logic er, g, rv;
        int pulses, last_ep, ep_p;
        logic fe_seen;

        total = 0;
        bad   = 0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 4'h0; bus.wdata = 32'h0;
        wake_evt = 1'b0;
        core_sleep = 1'b0;
        rst_n = 1'b0;

        tbl[0] = '{1'b1, 4'h4, 32'h0000_1234, 32'h0,          1'b0};
        tbl[1] = '{1'b0, 4'h4, 32'h0,         32'h0000_1234,  1'b0};
        tbl[2] = '{1'b1, 4'h4, 32'h0000_1000, 32'h0,          1'b0};
        tbl[3] = '{1'b0, 4'h4, 32'h0,         32'h0000_1000,  1'b0};
        tbl[4] = '{1'b0, 4'h0, 32'h0,         32'h0,          1'b0};
        tbl[5] = '{1'b0, 4'hC, 32'h0,         32'h0,          1'b0};
        tbl[6] = '{1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0,          1'b1};
        tbl[7] = '{1'b0, 4'h8, 32'h0,         32'h0,          1'b0};
        tbl[8] = '{1'b0, 4'h2, 32'h0,         32'h0,          1'b1};
        tbl[9] = '{1'b1, 4'h6, 32'h1,         32'h0,          1'b1};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_tile", {31'b0, tile_en}, 32'd0);
        chk("rst_fetch", {31'b0, fetch_en}, 32'd0);
        chk("rst_boot_addr", boot_addr, 32'h0);
        chk("rst_wu", {31'b0, wu_wfe}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rvalid", {31'b0, bus.rvalid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- register map table (IDLE) ----
        for (int i = 0; i < 10; i++) begin
            cfg_xfer(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er, g, rv);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
            chk($sformatf("vec%0d_gnt", i), {31'b0, g}, 32'd1);
            chk($sformatf("vec%0d_rvalid", i), {31'b0, rv}, 32'd1);
        end
        chk("boot_addr_pin", boot_addr, 32'h0000_1000);

        // ---- boot ----
        boot_seq("boot1");
        chk("boot1_busy", {31'b0, busy}, 32'd1);
        rd_status("boot1_status", 32'h0000_0002);

        // ---- illegal writes in RUN ----
        wr_reg("run_bootaddr_err", 4'h4, 32'hDEAD_BEEF, 1'b1);
        chk("run_bootaddr_kept", boot_addr, 32'h0000_1000);
        cfg_xfer(1'b1, 4'h8, 32'h1, rd, er, g, rv);
        chk("status_wr_err", {31'b0, er}, 32'd1);
        chk("status_wr_rdata", rd, 32'h0);
        wr_reg("start_in_run_noerr", 4'h0, 32'h1, 1'b0);
        rd_status("start_in_run_state", 32'h0000_0002);

        // ---- wake events and sleep episodes ----
        wake_evt = 1'b1;
        repeat (3) @(negedge clk);
        wake_evt = 1'b0;
        rd_status("evt3_status", 32'h0000_0302);
        pulses = 0;
        last_ep = 0;
        for (int ep = 0; ep < 4; ep++) begin
            core_sleep = 1'b1;
            ep_p = 0;
            repeat (3) begin
                #1 if (wu_wfe) ep_p++;
                @(negedge clk);
            end
            core_sleep = 1'b0;
            repeat (2) @(negedge clk);
            pulses += ep_p;
            last_ep = ep_p;
        end
        chk("wake_pulses", pulses, 32'd3);
        chk("wake_4th_episode", last_ep, 32'd0);
        rd_status("wake_cnt_zero", 32'h0000_0002);

        // ---- saturation ----
        wake_evt = 1'b1;
        repeat (20) @(negedge clk);
        wake_evt = 1'b0;
        rd_status("sat_status", 32'h0000_0F02);

        // ---- HALT in RUN, core awake: DRAIN holds ----
        wr_reg("halt_run_err", 4'h0, 32'h2, 1'b0);
        repeat (3) @(negedge clk);
        rd_status("drain_hold_status", 32'h0000_0F03);
        chk("drain_fetch", {31'b0, fetch_en}, 32'd0);
        chk("drain_tile", {31'b0, tile_en}, 32'd1);
        core_sleep = 1'b1;
        @(negedge clk);
        chk("drain_exit_busy", {31'b0, busy}, 32'd0);
        chk("drain_exit_tile", {31'b0, tile_en}, 32'd0);
        core_sleep = 1'b0;
        rd_status("drain_exit_cnt_clr", 32'h0000_0000);

        // ---- START+HALT together: HALT wins ----
        wr_reg("start_halt_err", 4'h0, 32'h3, 1'b0);
        chk("start_halt_idle", {31'b0, busy}, 32'd0);

        // ---- HALT in ENABLE at dly=3 ----
        wr_reg("en_start_err", 4'h0, 32'h1, 1'b0);
        fe_seen = fetch_en;
        repeat (4) begin
            @(negedge clk);
            fe_seen |= fetch_en;
        end
        wr_reg("en_halt_err", 4'h0, 32'h2, 1'b0);
        chk("en_halt_drain", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("en_halt_idle", {31'b0, busy}, 32'd0);
        chk("en_halt_tile", {31'b0, tile_en}, 32'd0);
        repeat (10) begin
            fe_seen |= fetch_en;
            @(negedge clk);
        end
        chk("en_halt_no_fetch", {31'b0, fe_seen}, 32'd0);

        // ---- coincident event, EVT write and wake pulse ----
        boot_seq("boot2");
        wake_evt = 1'b1;
        repeat (2) @(negedge clk);
        wake_evt = 1'b0;
        core_sleep = 1'b1;
        wake_evt = 1'b1;
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 4'hC; bus.wdata = 32'h0;
        #1 chk("coinc_wu", {31'b0, wu_wfe}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req = 1'b0; bus.we = 1'b0;
        wake_evt = 1'b0;
        core_sleep = 1'b0;
        chk("coinc_evt_err", {31'b0, bus.err}, 32'd0);
        rd_status("coinc_net_plus1", 32'h0000_0302);

        // ---- reset in RUN with counter 5 ----
        wake_evt = 1'b1;
        repeat (2) @(negedge clk);
        wake_evt = 1'b0;
        rd_status("pre_reset_cnt5", 32'h0000_0502);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tile", {31'b0, tile_en}, 32'd0);
        chk("mid_rst_fetch", {31'b0, fetch_en}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_boot_addr", boot_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_status("post_rst_status", 32'h0000_0000);
        boot_seq("boot3");
        rd_status("boot3_status", 32'h0000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
